// File: rtl/ws2812_strip_driver.sv
// WS2812 strip driver: LENGTH-pixel frame buffer streamed as one self-timed
// GRB serial frame with global brightness scaling and a trailing latch period.
module ws2812_strip_driver #(
  parameter int LENGTH     = 4,
  parameter int T0H_CYC    = 20,
  parameter int T1H_CYC    = 40,
  parameter int TBIT_CYC   = 62,
  parameter int TRESET_CYC = 2500,
  parameter int AW         = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic [7:0]    brightness,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          DO
);

  localparam int CW = $clog2(TBIT_CYC);
  localparam int LW = (TRESET_CYC > 1) ? $clog2(TRESET_CYC) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] T0H_W    = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H_W    = CW'(T1H_CYC);
  localparam logic [LW-1:0] LAT_LAST = LW'(TRESET_CYC - 1);
  localparam logic [AW-1:0] PIX_LAST = AW'(LENGTH - 1);
  localparam logic [AW:0]   LEN_W    = (AW + 1)'(LENGTH);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q;
  logic [4:0]    bit_q;
  logic [AW-1:0] pix_q;
  logic [LW-1:0] lat_q;
  logic          done_q;
  logic [7:0]    bright_q;
  logic [23:0]   shift_q;
  logic [23:0]   pix_buf [LENGTH];

  logic          bit_end, pix_end, frame_end, lat_end;
  logic [AW-1:0] pix_nxt;

  // out = c * (brightness + 1) >> 8, so 255 passes through and 0 blanks
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return 8'(prod >> 8);
  endfunction

  // Reorders {R,G,B} storage into G,R,B wire order while scaling
  function automatic logic [23:0] to_wire_grb(input logic [23:0] px, input logic [7:0] b);
    return {scale_ch(px[15:8], b), scale_ch(px[23:16], b), scale_ch(px[7:0], b)};
  endfunction

  assign bit_end   = (state_q == SEND) && (cyc_q == CYC_LAST);
  assign pix_end   = bit_end && (bit_q == 5'd23);
  assign frame_end = pix_end && (pix_q == PIX_LAST);
  assign lat_end   = (state_q == LATCH) && (lat_q == LAT_LAST);
  assign pix_nxt   = pix_q + AW'(1);
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    DO      = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND: begin
        DO = (cyc_q < (shift_q[23] ? T1H_W : T0H_W));
        if (frame_end) state_d = LATCH;
      end
      LATCH:   if (lat_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      lat_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= lat_end;
      if (state_q != SEND) begin
        cyc_q <= '0;
        bit_q <= '0;
        pix_q <= '0;
      end else if (bit_end) begin
        cyc_q <= '0;
        bit_q <= (bit_q == 5'd23) ? 5'd0 : bit_q + 5'd1;
        if (pix_end) pix_q <= frame_end ? '0 : pix_nxt;
      end else begin
        cyc_q <= cyc_q + CW'(1);
      end
      lat_q <= (state_q == LATCH && !lat_end) ? lat_q + LW'(1) : '0;
    end
  end

  // Datapath: buffer, brightness latch and bit shifter carry no reset
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < LEN_W)) pix_buf[wr_addr] <= wr_data;
    if (state_q == IDLE && start) bright_q <= brightness;
    if (state_q == LOAD)
      shift_q <= to_wire_grb(pix_buf[0], bright_q);
    else if (pix_end && !frame_end)
      shift_q <= to_wire_grb(pix_buf[pix_nxt], bright_q);
    else if (bit_end)
      shift_q <= {shift_q[22:0], 1'b0};
  end

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Directed/randomised bench for ws2812_strip_driver: decodes DO pulses and
// compares them with a per-pixel GRB model of buffer contents and brightness.
module tb_ws2812_strip_driver;

  localparam int T0H  = 20;
  localparam int T1H  = 40;
  localparam int TBIT = 62;
  localparam int TRST = 2500;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n;
  logic        wr_en0, start0, busy0, done0, do0;
  logic [1:0]  wr_addr0;
  logic [23:0] wr_data0;
  logic [7:0]  br0;
  logic        wr_en1, start1, busy1, done1, do1;
  logic [0:0]  wr_addr1;
  logic [23:0] wr_data1;
  logic [7:0]  br1;

  ws2812_strip_driver #(.LENGTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .brightness(br0), .start(start0), .busy(busy0), .done(done0), .DO(do0));

  ws2812_strip_driver #(.LENGTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .brightness(br1), .start(start1), .busy(busy1), .done(done1), .DO(do1));

  int checks = 0;
  int failures = 0;
  bit sel = 1'b0;
  logic cur_do, cur_busy, cur_done;
  logic [23:0] mbuf0 [4];
  logic [23:0] mbuf1;

  always_comb begin
    cur_do   = sel ? do1   : do0;
    cur_busy = sel ? busy1 : busy0;
    cur_done = sel ? done1 : done0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] sc(input int c, input int b);
    return 8'((c * (b + 1)) / 256);
  endfunction

  function automatic logic [23:0] grb(input logic [23:0] px, input int b);
    return {sc(int'(px[15:8]), b), sc(int'(px[23:16]), b), sc(int'(px[7:0]), b)};
  endfunction

  task automatic set_start(input logic v);
    if (sel) start1 = v; else start0 = v;
  endtask

  task automatic set_br(input logic [7:0] v);
    if (sel) br1 = v; else br0 = v;
  endtask

  task automatic wr(input int s, input int addr, input logic [23:0] d);
    @(negedge clk);
    if (s == 0) begin
      wr_en0 = 1'b1; wr_addr0 = 2'(addr); wr_data0 = d;
      if (addr < 4) mbuf0[addr] = d;
    end else begin
      wr_en1 = 1'b1; wr_addr1 = 1'(addr); wr_data1 = d;
      if (addr < 1) mbuf1 = d;
    end
    @(negedge clk);
    wr_en0 = 1'b0;
    wr_en1 = 1'b0;
  endtask

  // Starts a frame at the current negedge and decodes it until busy falls.
  // hold keeps start high; mw writes pixels 0 and 3 early in the frame;
  // rst_at > 0 pulls rst_n low at that cycle of the frame instead.
  task automatic frame(input int br, input bit hold, input bit mw, input int rst_at);
    int npix, i, last_rise, rise, nb, w, expw;
    logic [23:0] expx [$];
    bit expb [$];
    bit got [$];
    logic prev;
    logic [23:0] val;
    npix = sel ? 1 : 4;
    for (int p = 0; p < npix; p++) expx.push_back(grb(sel ? mbuf1 : mbuf0[p], br));
    if (mw) expx[3] = grb(24'hABCDEF, br);
    for (int p = 0; p < npix; p++)
      for (int k = 23; k >= 0; k--) expb.push_back(expx[p][k]);
    set_start(1'b1);
    set_br(8'(br));
    @(negedge clk);
    chk("busy_load", cur_busy, 1);
    chk("do_load", cur_do, 0);
    if (!hold) set_start(1'b0);
    set_br(8'($urandom_range(0, 255)));
    i = 0; last_rise = -1; rise = 0; nb = 0; prev = 1'b0;
    while (cur_busy) begin
      if (mw && i == 100) begin
        wr_en0 = 1'b1; wr_addr0 = 2'd0; wr_data0 = 24'h123456; mbuf0[0] = 24'h123456;
      end
      if (mw && i == 101) begin
        wr_addr0 = 2'd3; wr_data0 = 24'hABCDEF; mbuf0[3] = 24'hABCDEF;
      end
      if (mw && i == 102) wr_en0 = 1'b0;
      if (rst_at > 0 && i == rst_at) begin
        chk("do_mid_bit", cur_do, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_do", cur_do, 0);
        chk("rst_async_busy", cur_busy, 0);
        chk("rst_async_done", cur_done, 0);
        set_start(1'b0);
        repeat (3) @(negedge clk);
        chk("rst_hold_busy", cur_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      if (cur_do && !prev) begin
        if (last_rise >= 0) chk("bit_period", i - last_rise, TBIT);
        else chk("first_rise", i, 1);
        last_rise = i;
        rise = i;
      end
      if (!cur_do && prev) begin
        w = i - rise;
        expw = (nb < expb.size()) ? (expb[nb] ? T1H : T0H) : -1;
        chk("pulse_width", w, expw);
        got.push_back(w == T1H);
        nb++;
      end
      prev = cur_do;
      i++;
      if (i > 20000) begin
        chk("busy_timeout", i, 0);
        break;
      end
      @(negedge clk);
    end
    chk("busy_cycles", i, 1 + npix * 24 * TBIT + TRST);
    chk("latch_len", i - last_rise, TBIT + TRST);
    chk("done_pulse", cur_done, 1);
    chk("pulse_count", nb, npix * 24);
    for (int p = 0; p < npix; p++) begin
      val = '0;
      for (int k = 0; k < 24; k++)
        val = {val[22:0], ((p * 24 + k) < got.size()) ? got[p * 24 + k] : 1'bx};
      chk($sformatf("pixel%0d", p), val, expx[p]);
    end
    if (!hold) begin
      @(negedge clk);
      chk("done_clear", cur_done, 0);
      chk("idle_do", cur_do, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en0 = 0; start0 = 0; wr_addr0 = '0; wr_data0 = '0; br0 = '0;
    wr_en1 = 0; start1 = 0; wr_addr1 = '0; wr_data1 = '0; br1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_do0", do0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_do1", do1, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // colour order at full brightness
    wr(0, 0, 24'hFF0000); wr(0, 1, 24'h00FF00); wr(0, 2, 24'h0000FF); wr(0, 3, 24'hFFFFFF);
    frame(255, 0, 0, 0);

    // brightness scaling on white
    for (int p = 0; p < 4; p++) wr(0, p, 24'hFFFFFF);
    frame(128, 0, 0, 0);
    frame(0, 0, 0, 0);

    // start held across two frames
    wr(0, 0, 24'h13579B); wr(0, 2, 24'h2468AC);
    frame(255, 1, 0, 0);
    frame(200, 0, 0, 0);

    // writes during a frame: pixel 3 this frame, pixel 0 next frame
    frame(255, 0, 1, 0);
    frame(255, 0, 0, 0);

    // random contents, reset mid-bit of pixel 2, then a clean frame
    for (int p = 0; p < 4; p++) wr(0, p, 24'($urandom));
    frame($urandom_range(0, 255), 0, 0, 1 + 48 * TBIT + 5);
    repeat (4) @(negedge clk);
    frame($urandom_range(0, 255), 0, 0, 0);

    // single-LED instance, out-of-range write ignored
    sel = 1'b1;
    @(negedge clk);
    wr(1, 0, 24'($urandom));
    wr(1, 1, 24'h5A5A5A);
    frame(255, 0, 0, 0);
    frame($urandom_range(0, 255), 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
